mem_ctrl_arbiter: RTL
=====================

Name: mem_ctrl_arbiter

Overview:
- Shares the single-ported main memory between the icache and the dcache.
- Accepts block-level READ/WRITE requests from both caches, with fixed icache priority, and keeps one transaction outstanding to main memory at a time.
- Returns the response to the requesting cache as a single-cycle pulse.
- Sits between the two cache instances and the main memory model, at the top of the memory subsystem.

Parameters:
- STARVE_LIMIT, 4: consecutive icache grants tolerated while the dcache is waiting, before the dcache is forced through. Used only with MEM_CTRL_AGING_EN.

Ports:
- clk  in  1  clock
- rst_aL  in  1  asynchronous active-low reset
- icache_req_valid  in  1  icache miss request
- icache_req_type  in  req_type_t  READ/WRITE (icache issues READ only)
- icache_req_block_addr  in  main_mem_block_addr_t  block address
- icache_req_ready  out  1  grant to icache
- icache_resp_valid  out  1  response pulse to icache
- icache_resp_block_data  out  block_data_t  refill data
- dcache_req_valid  in  1  dcache miss or write-through request
- dcache_req_type  in  req_type_t  READ/WRITE
- dcache_req_block_addr  in  main_mem_block_addr_t  block address
- dcache_req_block_data  in  block_data_t  write data (WRITE only)
- dcache_req_ready  out  1  grant to dcache
- dcache_resp_valid  out  1  response pulse to dcache
- dcache_resp_block_data  out  block_data_t  refill data, or written block for WRITE
- main_mem_req_valid  out  1  request to memory
- main_mem_req_type  out  req_type_t  latched type
- main_mem_req_block_addr  out  main_mem_block_addr_t  latched address
- main_mem_req_block_data  out  block_data_t  latched write data
- main_mem_req_ready  in  1  memory accepts request
- main_mem_resp_valid  in  1  memory completes (READ data or WRITE ack)
- main_mem_resp_block_data  in  block_data_t  READ data
- proto_err  out  1  sticky: main_mem_resp_valid seen outside MEM_WAIT

Behaviour:
- Reset (async, rst_aL low): state=IDLE, owner=ICACHE, latched type/addr/data=0, starve_cnt=0.
  - All ready/valid outputs 0; all data outputs 0; proto_err=0.
  - Reset mid-transaction abandons the transaction with no response to either cache.
  - Main memory shares rst_aL, so no response is in flight after reset.
- FSM: IDLE -> MEM_REQ -> MEM_WAIT -> IDLE.
- IDLE:
  - icache_req_ready = icache_req_valid (combinational).
  - dcache_req_ready = dcache_req_valid & ~icache_req_valid.
  - On a grant: latch owner, type, addr and data (data forced to 0 for icache), then go to MEM_REQ next cycle.
  - At most one ready is high in any cycle; both readies are 0 outside IDLE.
- MEM_REQ:
  - main_mem_req_valid=1 and the latched fields are held stable until main_mem_req_ready.
  - On handshake, go to MEM_WAIT.
- MEM_WAIT:
  - Wait for main_mem_resp_valid; main memory never responds in the handshake cycle.
  - On response, pulse <owner>_resp_valid for exactly 1 cycle, combinationally, in the same cycle as main_mem_resp_valid. The caches are latency-sensitive to this pulse.
  - Response data: READ passes main_mem_resp_block_data through; WRITE returns the latched write block.
  - Next state is IDLE.
- Non-owner resp_valid is always 0; resp data is 0 whenever the matching resp_valid is 0.
- Minimum grant-to-grant spacing is 3 cycles: grant, MEM_REQ, MEM_WAIT with 1-cycle memory latency, then IDLE.
- Requests arriving while busy are not queued. The cache holds valid until it is granted.
- main_mem_resp_valid in IDLE or MEM_REQ is ignored, with no forwarding, and sets proto_err until reset.
- Latched fields change only on a grant.

Optional Feature:
- MEM_CTRL_AGING_EN defined:
  - starve_cnt increments on each icache grant while dcache_req_valid=1.
  - starve_cnt clears on any dcache grant, and on an icache grant with dcache_req_valid=0.
  - When starve_cnt==STARVE_LIMIT in IDLE and dcache_req_valid=1, the dcache wins even if the icache is valid.
  - starve_cnt saturates at STARVE_LIMIT.
- MEM_CTRL_AGING_EN undefined:
  - Strict icache priority; starve_cnt and its logic are absent.

Test Plan:
- icache READ 0x100, memory ready same cycle, resp after 1 cycle with data 0xDEADBEEF_CAFEF00D -> icache_req_ready in cycle 0; main_mem_req_valid in cycle 1 with addr 0x100; icache_resp_valid pulse in cycle 2 with that data; dcache_resp_valid=0 throughout.
- icache READ and dcache READ both valid in the same cycle -> icache granted first, dcache_req_ready=0; dcache granted in the first IDLE cycle after the icache response; two separate resp pulses to the correct caches.
- dcache WRITE addr 0x2A, data 0x11223344_55667788, main_mem_req_ready delayed 3 cycles -> main_mem_req fields stable for all 3 cycles; dcache_resp_valid on the memory ack carrying 0x11223344_55667788.
- main_mem_resp_valid pulsed in IDLE -> no resp_valid to either cache; proto_err=1 and held.
- rst_aL low during MEM_WAIT, memory resp arrives after reset released -> all outputs 0 while reset; no resp pulse; FSM in IDLE.
- MEM_CTRL_AGING_EN, STARVE_LIMIT=4, icache and dcache continuously valid -> grants are 4 icache then 1 dcache, repeating; without the macro the dcache is never granted.

Source files
------------

// File: rtl/mem_ctrl_arbiter_if.sv
// Block request/response bus shared by the icache, dcache and main-memory ports
// of mem_ctrl_arbiter. The requester drives req_* and receives req_ready plus a
// single-cycle resp_valid pulse carrying resp_block_data.
// req_type encoding: 1'b0 = READ, 1'b1 = WRITE.
interface mem_ctrl_arbiter_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 64
);
  logic                 req_valid;
  logic                 req_type;
  logic [AddrWidth-1:0] req_block_addr;
  logic [DataWidth-1:0] req_block_data;
  logic                 req_ready;
  logic                 resp_valid;
  logic [DataWidth-1:0] resp_block_data;

  // Requester side (cache, or the arbiter facing main memory).
  modport master (
    output req_valid, req_type, req_block_addr, req_block_data,
    input  req_ready, resp_valid, resp_block_data
  );

  // Responder side (the arbiter facing a cache, or main memory).
  modport slave (
    input  req_valid, req_type, req_block_addr, req_block_data,
    output req_ready, resp_valid, resp_block_data
  );
endinterface

// File: rtl/mem_ctrl_arbiter.sv
// Main-memory arbiter between the icache and dcache. One transaction is
// outstanding at a time: IDLE (grant) -> MEM_REQ (present latched request) ->
// MEM_WAIT (forward the response pulse to the owner) -> IDLE.
// The icache has fixed priority. Defining MEM_CTRL_AGING_EN adds a starvation
// counter that forces the dcache through after STARVE_LIMIT consecutive icache
// grants taken while the dcache was waiting.
module mem_ctrl_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned AddrWidth    = 32,
  parameter int unsigned DataWidth    = 64
) (
  input  logic                 clk,
  input  logic                 rst_aL,
  mem_ctrl_arbiter_if.slave    icache,
  mem_ctrl_arbiter_if.slave    dcache,
  mem_ctrl_arbiter_if.master   main_mem,
  output logic                 proto_err
);

  localparam logic ReqWrite = 1'b1;

  typedef enum logic [1:0] {StIdle, StMemReq, StMemWait} state_e;
  typedef enum logic {OwnIcache, OwnDcache} owner_e;

  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("STARVE_LIMIT must be at least 1");
  end

  state_e               state_q;
  owner_e               owner_q;
  logic                 type_q;
  logic [AddrWidth-1:0] addr_q;
  logic [DataWidth-1:0] data_q;
  logic                 proto_err_q;

  logic                 starved;
  logic                 dcache_wins;
  logic                 icache_grant;
  logic                 dcache_grant;
  logic                 resp_fire;
  logic [DataWidth-1:0] resp_data;

`ifdef MEM_CTRL_AGING_EN
  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

  logic [CntW-1:0] starve_q;

  assign starved = (starve_q == CntMax) && dcache.req_valid;

  // Count icache grants taken over a waiting dcache; any dcache grant or an
  // uncontested icache grant clears the streak.
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      starve_q <= '0;
    end else if (dcache_grant) begin
      starve_q <= '0;
    end else if (icache_grant) begin
      if (!dcache.req_valid) begin
        starve_q <= '0;
      end else if (starve_q != CntMax) begin
        starve_q <= starve_q + 1'b1;
      end
    end
  end
`else
  assign starved = 1'b0;
`endif

  // Grant decision: only in IDLE and never while reset is asserted, so at most
  // one ready is high and both are low while busy.
  always_comb begin
    dcache_wins  = dcache.req_valid & (~icache.req_valid | starved);
    icache_grant = rst_aL & (state_q == StIdle) & icache.req_valid & ~dcache_wins;
    dcache_grant = rst_aL & (state_q == StIdle) & dcache_wins;
  end

  // Response is forwarded combinationally in the same cycle as the memory
  // response; a WRITE echoes the latched block instead of memory data.
  always_comb begin
    resp_fire = (state_q == StMemWait) & main_mem.resp_valid;
    resp_data = (type_q == ReqWrite) ? data_q : main_mem.resp_block_data;
  end

  // Cache-facing outputs; data is zero whenever its valid is low.
  always_comb begin
    icache.req_ready       = icache_grant;
    dcache.req_ready       = dcache_grant;
    icache.resp_valid      = resp_fire & (owner_q == OwnIcache);
    dcache.resp_valid      = resp_fire & (owner_q == OwnDcache);
    icache.resp_block_data = icache.resp_valid ? resp_data : '0;
    dcache.resp_block_data = dcache.resp_valid ? resp_data : '0;
  end

  // Memory-facing outputs come straight from the latched request.
  always_comb begin
    main_mem.req_valid      = (state_q == StMemReq);
    main_mem.req_type       = type_q;
    main_mem.req_block_addr = addr_q;
    main_mem.req_block_data = data_q;
  end

  assign proto_err = proto_err_q;

  // Transaction FSM; request fields are latched only on a grant.
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      state_q <= StIdle;
      owner_q <= OwnIcache;
      type_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (icache_grant) begin
            owner_q <= OwnIcache;
            type_q  <= icache.req_type;
            addr_q  <= icache.req_block_addr;
            data_q  <= '0;
            state_q <= StMemReq;
          end else if (dcache_grant) begin
            owner_q <= OwnDcache;
            type_q  <= dcache.req_type;
            addr_q  <= dcache.req_block_addr;
            data_q  <= dcache.req_block_data;
            state_q <= StMemReq;
          end
        end
        StMemReq: begin
          if (main_mem.req_ready) begin
            state_q <= StMemWait;
          end
        end
        StMemWait: begin
          if (main_mem.resp_valid) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Sticky flag for a memory response arriving when none is expected.
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      proto_err_q <= 1'b0;
    end else if (main_mem.resp_valid && (state_q != StMemWait)) begin
      proto_err_q <= 1'b1;
    end
  end

endmodule
